unidade_controle_mc: RTL and testbench
======================================

// Module: unidade_controle_mc
// PURPOSE
// - Parametrised multicycle control FSM: drives PC/IR/memory/register-bank/ALU write enables and datapath mux selects.
// - Executes R-type add/sub/and, addi, lw, sw, beq, bne, j and the RESET opcode.
// - Has a configurable memory wait count and a reset-hold counter. Sits between IR (OPCODE/FUNCT) and the datapath.
// PARAMETERS
// - MEM_WAIT      1  extra wait cycles after each memory read (fetch and lw), 0..7
// - RESET_CYCLES  1  cycles reset_out stays high after reset is released, 1..7
// - ULA_W         3  width of ULA_c
// PORTS
// - clk        in   1      system clock, rising edge
// - reset      in   1      asynchronous, active-low reset
// - Of,Ng,Zr   in   1      ALU flags: overflow, negative, zero
// - Eq,Gt,Lt   in   1      ALU compare flags: equal, greater, less
// - OPCODE     in   6      IR[31:26]
// - FUNCT      in   6      IR[5:0]
// - PC_w       out  1      PC write enable
// - MEM_w      out  1      memory write enable
// - IR_w       out  1      IR write enable
// - RB_w       out  1      register-bank write enable
// - AB_w       out  1      A/B register write enable
// - ALUOUT_w   out  1      ALUOut register write enable
// - ULA_c      out  ULA_W  ALU op: 000 pass A, 001 add, 010 sub, 011 and
// - M_WREG     out  2      write-reg select: 0 rt, 1 rd, 2 r31
// - M_WDATA    out  1      write-data select: 0 ALUOut, 1 MDR
// - M_ULAA     out  1      ALU A select: 0 PC, 1 A
// - M_ULAB     out  2      ALU B select: 0 B, 1 const 4, 2 sign-ext imm, 3 imm<<2
// - M_PC       out  2      PC source: 0 ALU, 1 ALUOut, 2 jump target, 3 exception vector
// - M_ADDR     out  1      memory address select: 0 PC, 1 ALUOut
// - EPC_w      out  1      EPC write enable (0 when OVERFLOW_EXC_EN is undefined)
// - reset_out  out  1      datapath/stack reset, active-high
// BEHAVIOUR
// - Moore FSM. Outputs registered; each output equals its decode of the current state.
// - Any output not listed for a state is 0.
// - Async reset (reset==0): state=ST_RST, counter=0, reset_out=1, all other outputs 0. Takes effect immediately, mid-instruction included.
// - ST_RST: reset_out=1. Counts RESET_CYCLES clocks after reset releases, then goes to ST_FETCH.
// - ST_FETCH: M_ADDR=0, M_ULAA=0, M_ULAB=1, ULA_c=001. Goes to ST_FWAIT, or to ST_IRLD if MEM_WAIT=0.
// - ST_FWAIT: holds FETCH selects for MEM_WAIT cycles, then goes to ST_IRLD.
// - ST_IRLD: IR_w=1, PC_w=1, M_PC=0 (PC+4 is written). Goes to ST_DECODE.
// - ST_DECODE: AB_w=1, ALUOUT_w=1, M_ULAA=0, M_ULAB=3, ULA_c=001 (branch target). Dispatches on OPCODE.
// - Dispatch 0x00 -> EXEC_R.
// - Dispatch 0x08 -> EXEC_I.
// - Dispatch 0x23 or 0x2B -> MADDR.
// - Dispatch 0x04 or 0x05 -> BRANCH.
// - Dispatch 0x02 -> JUMP.
// - Dispatch 0x3F -> ST_RST, which reloads the reset counter.
// - Dispatch other -> ST_FETCH (no-op).
// - EXEC_R: M_ULAA=1, M_ULAB=0, ALUOUT_w=1. ULA_c from FUNCT: 0x20 add, 0x22 sub, 0x24 and.
// - EXEC_R with unknown FUNCT: returns to ST_FETCH with no write.
// - EXEC_I: M_ULAA=1, M_ULAB=2, ULA_c=001, ALUOUT_w=1.
// - WB_ALU: RB_w=1, M_WDATA=0. M_WREG=1 after EXEC_R, 0 after EXEC_I. Goes to ST_FETCH.
// - MADDR: M_ULAA=1, M_ULAB=2, ULA_c=001, ALUOUT_w=1. Goes to MREAD for lw, MWRITE for sw.
// - MREAD: M_ADDR=1. Waits MEM_WAIT cycles, then goes to WB_LOAD.
// - WB_LOAD: RB_w=1, M_WDATA=1, M_WREG=0. Goes to ST_FETCH.
// - MWRITE: M_ADDR=1, MEM_w=1 for exactly one cycle. Goes to ST_FETCH.
// - BRANCH: M_ULAA=1, M_ULAB=0, ULA_c=010, M_PC=1. PC_w = Eq for beq, !Eq for bne. Goes to ST_FETCH.
// - JUMP: PC_w=1, M_PC=2. Goes to ST_FETCH.
// - Wait counter is 3 bits, cleared on every state entry, and never wraps within one state.
// CONFIGURATION
// - OVERFLOW_EXC_EN defined:
//   - Of=1 sampled in EXEC_R (add/sub) or EXEC_I -> ST_EXC instead of WB_ALU. No register write.
//   - Unknown OPCODE or FUNCT -> ST_EXC.
//   - ST_EXC: EPC_w=1, M_ULAA=0, M_ULAB=1, ULA_c=010 (PC-4), PC_w=1, M_PC=3. Goes to ST_FETCH.
// - OVERFLOW_EXC_EN undefined:
//   - Of ignored; the overflowing result is written back.
//   - Unknown OPCODE/FUNCT is a no-op.
//   - EPC_w is tied to 0.
// TESTING
// - Reset: drive reset=0 mid-MREAD. All outputs 0 and reset_out=1 at once. After release, reset_out stays 1 for RESET_CYCLES clocks, then the FSM is in FETCH.
// - add (OPCODE 0x00, FUNCT 0x20), MEM_WAIT=1: IR_w at cycle 3, AB_w at 4, ALUOUT_w with ULA_c=001 at 5, RB_w with M_WREG=1 at 6.
// - lw 0x23, MEM_WAIT=2: MREAD lasts 3 cycles with M_ADDR=1, then a single RB_w pulse with M_WDATA=1. sw 0x2B: a single MEM_w pulse with M_ADDR=1.
// - beq 0x04 with Eq=1: PC_w=1, M_PC=1. With Eq=0: PC_w=0. bne 0x05 gives the inverse.
// - addi with Of=1: macro defined -> EPC_w=1, M_PC=3, no RB_w. Macro undefined -> RB_w=1.
// - OPCODE 0x3F in DECODE -> reset_out=1 for RESET_CYCLES cycles, then FETCH. OPCODE 0x3E -> back to FETCH, no enables asserted.

Source files
------------

// File: rtl/unidade_controle_mc.sv
// Multicycle control unit: Moore FSM driving datapath enables and mux selects.
// Optional overflow/illegal-instruction trap enabled by defining OVERFLOW_EXC_EN.
module unidade_controle_mc #(
  parameter int MEM_WAIT     = 1,
  parameter int RESET_CYCLES = 1,
  parameter int ULA_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Of,
  input  logic             Ng,
  input  logic             Zr,
  input  logic             Eq,
  input  logic             Gt,
  input  logic             Lt,
  input  logic [5:0]       OPCODE,
  input  logic [5:0]       FUNCT,
  output logic             PC_w,
  output logic             MEM_w,
  output logic             IR_w,
  output logic             RB_w,
  output logic             AB_w,
  output logic             ALUOUT_w,
  output logic [ULA_W-1:0] ULA_c,
  output logic [1:0]       M_WREG,
  output logic             M_WDATA,
  output logic             M_ULAA,
  output logic [1:0]       M_ULAB,
  output logic [1:0]       M_PC,
  output logic             M_ADDR,
  output logic             EPC_w,
  output logic             reset_out
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_FWAIT, S_IRLD, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU,
    S_MADDR, S_MREAD, S_WB_LOAD, S_MWRITE, S_BRANCH, S_JUMP, S_EXC
  } state_t;

  typedef struct packed {
    logic       pc_w;
    logic       mem_w;
    logic       ir_w;
    logic       rb_w;
    logic       ab_w;
    logic       aluout_w;
    logic [2:0] ula_c;
    logic [1:0] m_wreg;
    logic       m_wdata;
    logic       m_ulaa;
    logic [1:0] m_ulab;
    logic [1:0] m_pc;
    logic       m_addr;
    logic       epc_w;
    logic       reset_out;
  } ctrl_t;

  localparam logic [2:0] MW      = 3'(MEM_WAIT);
  localparam logic [2:0] MW_LAST = 3'((MEM_WAIT == 0) ? 0 : MEM_WAIT - 1);
  localparam logic [2:0] RC_LAST = 3'(RESET_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       ovf_trap;
  logic       funct_ok;
  logic       funct_arith;
  logic [2:0] r_op;

`ifdef OVERFLOW_EXC_EN
  localparam state_t S_ILLEGAL = S_EXC;
  assign ovf_trap = Of;
  logic unused_flags;
  assign unused_flags = ^{Ng, Zr, Gt, Lt};
`else
  localparam state_t S_ILLEGAL = S_FETCH;
  assign ovf_trap = 1'b0;
  logic unused_flags;
  assign unused_flags = ^{Of, Ng, Zr, Gt, Lt, ctrl_q.epc_w};
`endif

  always_comb begin
    r_op        = 3'b000;
    funct_ok    = 1'b1;
    funct_arith = 1'b1;
    case (FUNCT)
      6'h20:   r_op = 3'b001;
      6'h22:   r_op = 3'b010;
      6'h24: begin
        r_op        = 3'b011;
        funct_arith = 1'b0;
      end
      default: begin
        funct_ok    = 1'b0;
        funct_arith = 1'b0;
      end
    endcase
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    if (cnt_q >= RC_LAST) state_d = S_FETCH;
      S_FETCH:  state_d = (MEM_WAIT == 0) ? S_IRLD : S_FWAIT;
      S_FWAIT:  if (cnt_q >= MW_LAST) state_d = S_IRLD;
      S_IRLD:   state_d = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          6'h00:        state_d = S_EXEC_R;
          6'h08:        state_d = S_EXEC_I;
          6'h23, 6'h2B: state_d = S_MADDR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          6'h3F:        state_d = S_RST;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        if (!funct_ok)                     state_d = S_ILLEGAL;
        else if (ovf_trap && funct_arith)  state_d = S_EXC;
        else                               state_d = S_WB_ALU;
      end
      S_EXEC_I: state_d = ovf_trap ? S_EXC : S_WB_ALU;
      S_MADDR:  state_d = (OPCODE == 6'h23) ? S_MREAD : S_MWRITE;
      S_MREAD:  if (cnt_q >= MW) state_d = S_WB_LOAD;
      S_WB_ALU, S_WB_LOAD, S_MWRITE, S_BRANCH, S_JUMP, S_EXC: state_d = S_FETCH;
      default:  state_d = S_RST;
    endcase

    // Counter restarts on every state change and saturates instead of wrapping.
    if (state_d != state_q)   cnt_d = 3'd0;
    else if (cnt_q == 3'd7)   cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 3'd1;
  end

  // Outputs are decoded from the next state and registered, so the flops
  // always hold the decode of the state being entered.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_RST: ctrl_d.reset_out = 1'b1;
      S_FETCH, S_FWAIT: begin
        ctrl_d.m_ulab = 2'd1;
        ctrl_d.ula_c  = 3'b001;
      end
      S_IRLD: begin
        ctrl_d.ir_w = 1'b1;
        ctrl_d.pc_w = 1'b1;
      end
      S_DECODE: begin
        ctrl_d.ab_w     = 1'b1;
        ctrl_d.aluout_w = 1'b1;
        ctrl_d.m_ulab   = 2'd3;
        ctrl_d.ula_c    = 3'b001;
      end
      S_EXEC_R: begin
        ctrl_d.m_ulaa   = 1'b1;
        ctrl_d.aluout_w = funct_ok;
        ctrl_d.ula_c    = r_op;
      end
      S_EXEC_I, S_MADDR: begin
        ctrl_d.m_ulaa   = 1'b1;
        ctrl_d.m_ulab   = 2'd2;
        ctrl_d.ula_c    = 3'b001;
        ctrl_d.aluout_w = 1'b1;
      end
      S_WB_ALU: begin
        ctrl_d.rb_w   = 1'b1;
        ctrl_d.m_wreg = (state_q == S_EXEC_R) ? 2'd1 : 2'd0;
      end
      S_MREAD: ctrl_d.m_addr = 1'b1;
      S_WB_LOAD: begin
        ctrl_d.rb_w    = 1'b1;
        ctrl_d.m_wdata = 1'b1;
      end
      S_MWRITE: begin
        ctrl_d.m_addr = 1'b1;
        ctrl_d.mem_w  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.m_ulaa = 1'b1;
        ctrl_d.ula_c  = 3'b010;
        ctrl_d.m_pc   = 2'd1;
      end
      S_JUMP: begin
        ctrl_d.pc_w = 1'b1;
        ctrl_d.m_pc = 2'd2;
      end
      S_EXC: begin
        ctrl_d.epc_w  = 1'b1;
        ctrl_d.m_ulab = 2'd1;
        ctrl_d.ula_c  = 3'b010;
        ctrl_d.pc_w   = 1'b1;
        ctrl_d.m_pc   = 2'd3;
      end
      default: ctrl_d = '0;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_RST;
      cnt_q            <= 3'd0;
      ctrl_q           <= '0;
      ctrl_q.reset_out <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // The branch decision uses the compare flags produced during BRANCH itself.
  assign PC_w      = ctrl_q.pc_w | ((state_q == S_BRANCH) & (Eq ^ (OPCODE == 6'h05)));
  assign MEM_w     = ctrl_q.mem_w;
  assign IR_w      = ctrl_q.ir_w;
  assign RB_w      = ctrl_q.rb_w;
  assign AB_w      = ctrl_q.ab_w;
  assign ALUOUT_w  = ctrl_q.aluout_w;
  assign ULA_c     = ULA_W'(ctrl_q.ula_c);
  assign M_WREG    = ctrl_q.m_wreg;
  assign M_WDATA   = ctrl_q.m_wdata;
  assign M_ULAA    = ctrl_q.m_ulaa;
  assign M_ULAB    = ctrl_q.m_ulab;
  assign M_PC      = ctrl_q.m_pc;
  assign M_ADDR    = ctrl_q.m_addr;
  assign reset_out = ctrl_q.reset_out;
`ifdef OVERFLOW_EXC_EN
  assign EPC_w     = ctrl_q.epc_w;
`else
  assign EPC_w     = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Self-checking bench for unidade_controle_mc: each instruction is expanded into its
// expected per-cycle control trace from the instruction timing rules and compared cycle by cycle.
`timescale 1ns/1ps
module tb_unidade_controle_mc;

  localparam int MEM_WAIT     = 2;
  localparam int RESET_CYCLES = 3;
  localparam int ULA_W        = 3;
`ifdef OVERFLOW_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic Of, Ng, Zr, Eq, Gt, Lt;
  logic [5:0] OPCODE, FUNCT;
  logic PC_w, MEM_w, IR_w, RB_w, AB_w, ALUOUT_w, M_WDATA, M_ULAA, M_ADDR, EPC_w, reset_out;
  logic [ULA_W-1:0] ULA_c;
  logic [1:0] M_WREG, M_ULAB, M_PC;

  unidade_controle_mc #(
    .MEM_WAIT(MEM_WAIT), .RESET_CYCLES(RESET_CYCLES), .ULA_W(ULA_W)
  ) dut (
    .clk(clk), .reset(reset), .Of(Of), .Ng(Ng), .Zr(Zr), .Eq(Eq), .Gt(Gt), .Lt(Lt),
    .OPCODE(OPCODE), .FUNCT(FUNCT), .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w),
    .RB_w(RB_w), .AB_w(AB_w), .ALUOUT_w(ALUOUT_w), .ULA_c(ULA_c), .M_WREG(M_WREG),
    .M_WDATA(M_WDATA), .M_ULAA(M_ULAA), .M_ULAB(M_ULAB), .M_PC(M_PC), .M_ADDR(M_ADDR),
    .EPC_w(EPC_w), .reset_out(reset_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_w, mem_w, ir_w, rb_w, ab_w, aluout_w;
    logic [2:0] ula_c;
    logic [1:0] m_wreg;
    logic       m_wdata, m_ulaa;
    logic [1:0] m_ulab, m_pc;
    logic       m_addr, epc_w, reset_out;
  } ctl_t;

  ctl_t got;
  assign got = {PC_w, MEM_w, IR_w, RB_w, AB_w, ALUOUT_w, ULA_c, M_WREG, M_WDATA,
                M_ULAA, M_ULAB, M_PC, M_ADDR, EPC_w, reset_out};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t v_rst();
    ctl_t c = '0; c.reset_out = 1'b1; return c;
  endfunction
  function automatic ctl_t v_fetch();
    ctl_t c = '0; c.m_ulab = 2'd1; c.ula_c = 3'b001; return c;
  endfunction
  function automatic ctl_t v_exc();
    ctl_t c = '0;
    c.epc_w = 1'b1; c.m_ulab = 2'd1; c.ula_c = 3'b010; c.pc_w = 1'b1; c.m_pc = 2'd3;
    return c;
  endfunction
  function automatic ctl_t v_wb(input logic [1:0] wreg);
    ctl_t c = '0; c.rb_w = 1'b1; c.m_wreg = wreg; return c;
  endfunction
  function automatic ctl_t v_imm_add();
    ctl_t c = '0;
    c.m_ulaa = 1'b1; c.m_ulab = 2'd2; c.ula_c = 3'b001; c.aluout_w = 1'b1;
    return c;
  endfunction

  ctl_t exp_q[$];

  // Builds the expected trace for one instruction, starting at its FETCH cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic eq, input logic of);
    ctl_t c;
    logic known;
    exp_q.delete();
    repeat (1 + MEM_WAIT) exp_q.push_back(v_fetch());
    c = '0; c.ir_w = 1'b1; c.pc_w = 1'b1; exp_q.push_back(c);
    c = '0; c.ab_w = 1'b1; c.aluout_w = 1'b1; c.m_ulab = 2'd3; c.ula_c = 3'b001;
    exp_q.push_back(c);
    case (op)
      6'h00: begin
        known = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24);
        c = '0; c.m_ulaa = 1'b1; c.aluout_w = known;
        c.ula_c = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b000;
        exp_q.push_back(c);
        if (!known) begin
          if (EXC_EN) exp_q.push_back(v_exc());
        end else if (EXC_EN && of && fn != 6'h24) exp_q.push_back(v_exc());
        else exp_q.push_back(v_wb(2'd1));
      end
      6'h08: begin
        exp_q.push_back(v_imm_add());
        exp_q.push_back((EXC_EN && of) ? v_exc() : v_wb(2'd0));
      end
      6'h23: begin
        exp_q.push_back(v_imm_add());
        c = '0; c.m_addr = 1'b1;
        repeat (MEM_WAIT + 1) exp_q.push_back(c);
        c = '0; c.rb_w = 1'b1; c.m_wdata = 1'b1; exp_q.push_back(c);
      end
      6'h2B: begin
        exp_q.push_back(v_imm_add());
        c = '0; c.m_addr = 1'b1; c.mem_w = 1'b1; exp_q.push_back(c);
      end
      6'h04, 6'h05: begin
        c = '0; c.m_ulaa = 1'b1; c.ula_c = 3'b010; c.m_pc = 2'd1;
        c.pc_w = (op == 6'h04) ? eq : !eq;
        exp_q.push_back(c);
      end
      6'h02: begin
        c = '0; c.pc_w = 1'b1; c.m_pc = 2'd2; exp_q.push_back(c);
      end
      6'h3F: repeat (RESET_CYCLES) exp_q.push_back(v_rst());
      default: if (EXC_EN) exp_q.push_back(v_exc());
    endcase
  endtask

  // Plays one instruction; abort_at >= 0 pulls reset low during that cycle.
  task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn,
                     input logic eq, input logic of, input int abort_at);
    OPCODE = op; FUNCT = fn; Eq = eq; Of = of;
    Ng = 1'($urandom); Zr = 1'($urandom); Gt = 1'($urandom); Lt = 1'($urandom);
    build(op, fn, eq, of);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", name, i), 32'(got), 32'(exp_q[i]));
      if (i == abort_at) begin
        #2 reset = 1'b0;
        #1 check($sformatf("%s_async_rst", name), 32'(got), 32'(v_rst()));
        @(posedge clk); @(negedge clk);
        check($sformatf("%s_rst_hold", name), 32'(got), 32'(v_rst()));
        reset = 1'b1;
        for (int k = 0; k < RESET_CYCLES; k++) begin
          check($sformatf("%s_rst_rel[%0d]", name, k), 32'(got), 32'(v_rst()));
          @(posedge clk); @(negedge clk);
        end
        return;
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  logic [5:0] known_ops [8] = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

  function automatic bit is_known(input logic [5:0] op);
    foreach (known_ops[i]) if (known_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [5:0] op, fn;
    int sel;
    reset = 1'b0; Of = 0; Ng = 0; Zr = 0; Eq = 0; Gt = 0; Lt = 0;
    OPCODE = 6'h00; FUNCT = 6'h00;
    repeat (2) @(negedge clk);
    check("por", 32'(got), 32'(v_rst()));
    reset = 1'b1;
    for (int k = 0; k < RESET_CYCLES; k++) begin
      check($sformatf("por_rel[%0d]", k), 32'(got), 32'(v_rst()));
      @(posedge clk); @(negedge clk);
    end

    run("add",      6'h00, 6'h20, 1'b0, 1'b0, -1);
    run("sub",      6'h00, 6'h22, 1'b1, 1'b0, -1);
    run("and",      6'h00, 6'h24, 1'b0, 1'b1, -1);
    run("r_badfn",  6'h00, 6'h3A, 1'b0, 1'b0, -1);
    run("addi",     6'h08, 6'h00, 1'b0, 1'b0, -1);
    run("addi_ovf", 6'h08, 6'h00, 1'b0, 1'b1, -1);
    run("add_ovf",  6'h00, 6'h20, 1'b0, 1'b1, -1);
    run("lw",       6'h23, 6'h00, 1'b0, 1'b0, -1);
    run("sw",       6'h2B, 6'h00, 1'b0, 1'b0, -1);
    run("beq_t",    6'h04, 6'h00, 1'b1, 1'b0, -1);
    run("beq_nt",   6'h04, 6'h00, 1'b0, 1'b0, -1);
    run("bne_t",    6'h05, 6'h00, 1'b0, 1'b0, -1);
    run("bne_nt",   6'h05, 6'h00, 1'b1, 1'b0, -1);
    run("j",        6'h02, 6'h00, 1'b0, 1'b0, -1);
    run("op3f",     6'h3F, 6'h00, 1'b0, 1'b0, -1);
    run("op3e",     6'h3E, 6'h00, 1'b0, 1'b0, -1);
    // Abort on the second MREAD cycle of a load.
    run("lw_rst",   6'h23, 6'h00, 1'b0, 1'b0, MEM_WAIT + 5);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 8);
      if (sel < 8) op = known_ops[sel];
      else begin
        op = 6'($urandom_range(0, 63));
        while (is_known(op)) op = 6'($urandom_range(0, 63));
      end
      case ($urandom_range(0, 3))
        0:       fn = 6'h20;
        1:       fn = 6'h22;
        2:       fn = 6'h24;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      run($sformatf("rnd%0d_op%02h", n, op), op, fn, 1'($urandom), 1'($urandom), -1);
    end

    check("idle_fetch", 32'(got), 32'(v_fetch()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
